// File: rtl/aes_dec128_iter.sv
// Iterative AES-128 decryptor: one key-schedule step or one inverse round per clock.
// The round key register is expanded forward to rk10, then rolled back one step per
// inverse round, so no round-key table is stored.
// Optional feature macro: AES_DEC_KEY_CACHE_EN (keeps the last key and its rk10 so a
// repeated key skips the forward expansion).
module aes_dec128_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ct,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] pt,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_e;

  state_e       fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d;
  logic [127:0] st_q, st_d;
  logic [127:0] ct_q, ct_d;

`ifdef AES_DEC_KEY_CACHE_EN
  logic         cache_vld_q, cache_vld_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic [127:0] cache_rk10_q, cache_rk10_d;
`endif

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, reduction polynomial 0x11B. The S-boxes are computed
  // algebraically (field inverse plus affine map) rather than tabulated.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // a^254 via an addition chain; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    a252 = gf_mul(a240, a12);
    return gf_mul(a252, a2);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Key schedule datapath, shared by the forward and backward steps.
  // Words: w0 = key_q[127:96] ... w3 = key_q[31:0].
  // Forward uses w3 of rk_r; backward recovers w3 of rk_{r-1} as w3^w2 first.
  // ---------------------------------------------------------------------------
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sb_in, rot_w, sb_out, t_word;
  logic [3:0]   rcon_idx;
  logic [127:0] key_fwd, key_back;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign sb_in    = (fsm_q == ROUND) ? (w3 ^ w2) : w3;
  assign rot_w    = {sb_in[23:0], sb_in[31:24]};
  assign rcon_idx = (fsm_q == ROUND) ? (cnt_q + 4'd1) : cnt_q;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_ksbox
    assign sb_out[31-8*gi -: 8] = sbox_fwd(rot_w[31-8*gi -: 8]);
  end

  assign t_word = sb_out ^ {rcon(rcon_idx), 24'h000000};

  assign key_fwd[127:96] = w0 ^ t_word;
  assign key_fwd[95:64]  = w1 ^ key_fwd[127:96];
  assign key_fwd[63:32]  = w2 ^ key_fwd[95:64];
  assign key_fwd[31:0]   = w3 ^ key_fwd[63:32];

  assign key_back[127:96] = w0 ^ t_word;
  assign key_back[95:64]  = w1 ^ w0;
  assign key_back[63:32]  = w2 ^ w1;
  assign key_back[31:0]   = w3 ^ w2;

  // ---------------------------------------------------------------------------
  // Inverse round datapath: InvShiftRows + InvSubBytes, AddRoundKey, InvMixColumns.
  // Byte i sits at bits [127-8i -: 8], row = i%4, column = i/4.
  // ---------------------------------------------------------------------------
  logic [127:0] isb, ark, imc, rnd_out;

  for (gi = 0; gi < 16; gi++) begin : g_byte
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = R + 4 * ((C + 4 - R) % 4);
    assign isb[127-8*gi -: 8] = sbox_inv(st_q[127-8*SRC -: 8]);
  end

  assign ark = isb ^ key_back;

  for (gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*gi -: 8];
    assign a1 = ark[119-32*gi -: 8];
    assign a2 = ark[111-32*gi -: 8];
    assign a3 = ark[103-32*gi -: 8];
    assign imc[127-32*gi -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign imc[119-32*gi -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign imc[111-32*gi -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign imc[103-32*gi -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  // the last round (counter 0) omits InvMixColumns
  assign rnd_out = (cnt_q == 4'd0) ? ark : imc;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q != IDLE);
  assign out_valid = (fsm_q == DONE);
  assign pt        = st_q;

  // next-state and datapath register updates for the four-state sequencer
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    key_d = key_q;
    st_d  = st_q;
    ct_d  = ct_q;
`ifdef AES_DEC_KEY_CACHE_EN
    cache_vld_d  = cache_vld_q;
    cache_key_d  = cache_key_q;
    cache_rk10_d = cache_rk10_q;
`endif
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          ct_d  = ct;
          fsm_d = KEXP;
`ifdef AES_DEC_KEY_CACHE_EN
          if (cache_vld_q && (key == cache_key_q)) begin
            // hit: jump straight to the whitening step with rk10 preloaded
            key_d = cache_rk10_q;
            cnt_d = 4'd11;
          end else begin
            key_d       = key;
            cnt_d       = 4'd1;
            cache_vld_d = 1'b0;
            cache_key_d = key;
          end
`else
          key_d = key;
          cnt_d = 4'd1;
`endif
        end
      end
      KEXP: begin
        if (cnt_q == 4'd11) begin
          // rk10 is now held; whiten the ciphertext and start the inverse rounds
          st_d  = ct_q ^ key_q;
          cnt_d = 4'd9;
          fsm_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          cache_vld_d  = 1'b1;
          cache_rk10_d = key_q;
`endif
        end else begin
          key_d = key_fwd;
          cnt_d = cnt_q + 4'd1;
        end
      end
      ROUND: begin
        st_d  = rnd_out;
        key_d = key_back;
        if (cnt_q == 4'd0) fsm_d = DONE;
        else               cnt_d = cnt_q - 4'd1;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously so an in-flight block is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q <= IDLE;
      cnt_q <= 4'd0;
      key_q <= '0;
      st_q  <= '0;
      ct_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
      st_q  <= st_d;
      ct_q  <= ct_d;
    end
  end

`ifdef AES_DEC_KEY_CACHE_EN
  // expanded-key cache; any reset invalidates it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_vld_q  <= 1'b0;
      cache_key_q  <= '0;
      cache_rk10_q <= '0;
    end else begin
      cache_vld_q  <= cache_vld_d;
      cache_key_q  <= cache_key_d;
      cache_rk10_q <= cache_rk10_d;
    end
  end
`endif

endmodule

// File: tb/tb_aes_dec128_iter.sv
// Directed bench for aes_dec128_iter: known-answer vectors, latency, back-pressure,
// mid-flight reset and the no-accept-in-DONE rule.
module tb_aes_dec128_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;
  logic         busy;

  int errors = 0;
  int checks = 0;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Z_CT     = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] AB_CT    = 128'h0545aad56da2a97c3663d1432a3d1c84;
  localparam logic [127:0] ONE_CT   = 128'h58e2fccefa7e3061367f1d57a4e7455a;

  aes_dec128_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct        (ct),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt        (pt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // offer one block; returns right after the accepting edge and scrambles the inputs
  task automatic offer(input logic [127:0] c, input logic [127:0] k);
    @(negedge clk);
    in_valid = 1'b1;
    ct       = c;
    key      = k;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ct       = ~c;
    key      = ~k;
  endtask

  // count edges from acceptance until out_valid is seen (bounded)
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    int lat;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ct = '0; key = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (pt !== 128'h0) begin errors++; $display("FAIL rst_pt: got %h expected 0", pt); end
    // release and offer on the very first rising edge with rst high
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; ct = FIPS_CT; key = FIPS_KEY;
    @(posedge clk);
    #1;
    in_valid = 1'b0; ct = '1; key = '0;
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL first_accept: busy=%b in_ready=%b expected 1/0", busy, in_ready); end
    wait_out(lat);
    checks++; if (lat !== 21) begin errors++; $display("FAIL fips_latency: got %0d expected 21", lat); end
    checks++; if (pt !== FIPS_PT) begin errors++; $display("FAIL fips_pt: got %h expected %h", pt, FIPS_PT); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fips_handshake: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    $display("txn fips: latency=%0d pt=%h", lat, pt);
  endtask

  task automatic test_stall;
    int lat;
    out_ready = 1'b0;
    offer(Z_CT, 128'h0);
    wait_out(lat);
    checks++; if (lat !== 21) begin errors++; $display("FAIL stall_latency: got %0d expected 21", lat); end
    checks++; if (pt !== 128'h0) begin errors++; $display("FAIL stall_pt: got %h expected 0", pt); end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || pt !== 128'h0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b pt=%h expected 1/0/0", i, out_valid, in_ready, pt);
      end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stall_release: out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
    $display("txn stall: latency=%0d pt=%h held 15 cycles", lat, pt);
  endtask

  task automatic test_abort;
    int lat;
    out_ready = 1'b1;
    offer(AB_CT, 128'h1);
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (pt !== 128'h0) begin errors++; $display("FAIL abort_pt: got %h expected 0", pt); end
    @(negedge clk); rst = 1'b1;
    // re-run with the zero-key, zero-plaintext known answer
    offer(Z_CT, 128'h0);
    wait_out(lat);
    checks++; if (lat !== 21) begin errors++; $display("FAIL rerun_latency: got %0d expected 21", lat); end
    checks++; if (pt !== 128'h0) begin errors++; $display("FAIL rerun_pt: got %h expected 0", pt); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rerun_handshake: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    $display("txn abort+rerun: latency=%0d pt=%h", lat, pt);
  endtask

  task automatic test_kat2;
    int lat;
    out_ready = 1'b1;
    offer(C1_CT, C1_KEY);
    wait_out(lat);
    checks++; if (lat !== 21) begin errors++; $display("FAIL c1_latency: got %0d expected 21", lat); end
    checks++; if (pt !== C1_PT) begin errors++; $display("FAIL c1_pt: got %h expected %h", pt, C1_PT); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL c1_handshake: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    $display("txn c1: latency=%0d pt=%h", lat, pt);
  endtask

  task automatic test_back_to_back;
    int lat1;
    int lat2;
    out_ready = 1'b1;
    offer(ONE_CT, 128'h0);
    wait_out(lat1);
    checks++; if (lat1 !== 21) begin errors++; $display("FAIL b2b_lat1: got %0d expected 21", lat1); end
    checks++; if (pt !== 128'h1) begin errors++; $display("FAIL b2b_pt1: got %h expected 1", pt); end
    $display("txn b2b first: latency=%0d pt=%h", lat1, pt);
    // offer the next block while DONE hands off; it must not be taken on that edge
    @(negedge clk);
    in_valid = 1'b1; ct = ONE_CT; key = 128'h0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL done_no_accept: out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy); end
    @(posedge clk); #1;
    in_valid = 1'b0; ct = '1; key = '1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy=%b expected 1", busy); end
    wait_out(lat2);
    checks++; if (lat2 !== HIT_LAT) begin errors++; $display("FAIL b2b_lat2: got %0d expected %0d", lat2, HIT_LAT); end
    checks++; if (pt !== 128'h1) begin errors++; $display("FAIL b2b_pt2: got %h expected 1", pt); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_handshake: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    $display("txn b2b second: latency=%0d pt=%h", lat2, pt);
  endtask

  initial begin
    test_reset();
    test_stall();
    test_abort();
    test_kat2();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
